// File: rtl/crc_frame_serializer_if.sv
// Handshake and serial-link bundle for crc_frame_serializer.
// slave is the serializer side; master is the feeder/CRC-generator side.
interface crc_frame_serializer_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  P_VALID;
  logic                  P_READY;
  logic                  DATA;
  logic                  ACTIVE;
  logic                  CRC_VALID;
  logic                  BUSY;
  logic                  FRAME_DONE;
  logic                  TIMEOUT_ERR;

  modport slave (
    input  P_DATA,
    input  P_VALID,
    input  CRC_VALID,
    output P_READY,
    output DATA,
    output ACTIVE,
    output BUSY,
    output FRAME_DONE,
    output TIMEOUT_ERR
  );

  modport master (
    output P_DATA,
    output P_VALID,
    output CRC_VALID,
    input  P_READY,
    input  DATA,
    input  ACTIVE,
    input  BUSY,
    input  FRAME_DONE,
    input  TIMEOUT_ERR
  );

endinterface

// File: rtl/crc_frame_serializer.sv
// Serializes one parallel word per frame LSB-first, then holds off the next word until the
// downstream CRC generator has finished its CRC shift-out (or a drain timeout expires).
module crc_frame_serializer #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  crc_frame_serializer_if.slave    bus
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned TmoW = $clog2(DRAIN_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StShift, StDrain} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                  seen_q, seen_d;
  logic                  p_ready_q, p_ready_d;
  logic                  data_q, data_d;
  logic                  active_q, active_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tmo_err_q, tmo_err_d;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    seen_d    = seen_q;
    p_ready_d = p_ready_q;
    data_d    = data_q;
    active_d  = active_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tmo_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        p_ready_d = 1'b1;
        // Bit 0 goes straight out on the accept edge; the rest wait in sr_q.
        if (bus.P_VALID && p_ready_q) begin
          sr_d      = bus.P_DATA >> 1;
          bit_cnt_d = '0;
          data_d    = bus.P_DATA[0];
          active_d  = 1'b1;
          p_ready_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = StShift;
        end
      end

      StShift: begin
        if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
          active_d  = 1'b0;
          data_d    = 1'b0;
          tmo_cnt_d = '0;
          seen_d    = 1'b0;
          state_d   = StDrain;
        end else begin
          data_d    = sr_q[0];
          sr_d      = sr_q >> 1;
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end

      StDrain: begin
        if (bus.CRC_VALID) begin
          seen_d = 1'b1;
        end
        // Falling CRC_VALID wins over a timeout landing on the same edge.
        if (seen_q && !bus.CRC_VALID) begin
          done_d    = 1'b1;
          p_ready_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end else if (tmo_cnt_q == TmoW'(DRAIN_TIMEOUT - 1)) begin
          tmo_err_d = 1'b1;
          p_ready_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      tmo_cnt_q <= '0;
      seen_q    <= 1'b0;
      p_ready_q <= 1'b0;
      data_q    <= 1'b0;
      active_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      seen_q    <= seen_d;
      p_ready_q <= p_ready_d;
      data_q    <= data_d;
      active_q  <= active_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign bus.P_READY     = p_ready_q;
  assign bus.DATA        = data_q;
  assign bus.ACTIVE      = active_q;
  assign bus.BUSY        = busy_q;
  assign bus.FRAME_DONE  = done_q;
  assign bus.TIMEOUT_ERR = tmo_err_q;

endmodule
